// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
//   Captures PPU pixels into a small output FIFO, one frame at a time.
//   A capture is requested with cap_start. The controller waits for a frame
//   rise, then tags each qualified pixel with its (x,y) position until
//   cap_frames frames have closed (0 = run until cap_abort).
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   pixel, pixel_en : PPU pixel (bits [5:0] = palette index) and qualifier
//   frame           : PPU frame level, a rising edge starts a frame
//   cap_start       : one-cycle capture request, samples cap_frames
//   cap_frames      : frames to capture, 0 = unlimited
//   cap_abort       : one-cycle abort, flushes the FIFO, no done pulse
//   wr_*            : output entry stream (valid/ready), head of the FIFO
//   busy            : controller not idle
//   done            : one-cycle pulse when a capture completes normally
//   frame_cnt       : frames closed in the current capture (saturating)
//   err             : sticky {ovf, long, short}, cleared by cap_start
//   state_dbg       : current controller state, for observation
//
// Output handshake: wr_valid is high while the FIFO holds an entry and the
// wr_* fields show that entry; it is consumed on a cycle where wr_valid and
// wr_ready are both high. wr_valid never depends on wr_ready.
module frame_capture_ctrl #(
    parameter int IMAGE_W    = 256,
    parameter int IMAGE_H    = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pixel,
    input  logic        pixel_en,
    input  logic        frame,
    input  logic        cap_start,
    input  logic [15:0] cap_frames,
    input  logic        cap_abort,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [8:0]  wr_x,
    output logic [7:0]  wr_y,
    output logic [5:0]  wr_data,
    output logic        wr_sof,
    output logic        wr_eof,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt,
    output logic [2:0]  err,
    output logic [1:0]  state_dbg
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [8:0]    X_LAST    = 9'(IMAGE_W - 1);
    localparam logic [8:0]    Y_LAST    = 9'(IMAGE_H - 1);
    localparam logic [8:0]    Y_FULL    = 9'(IMAGE_H);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [5:0] data;
        logic       sof;
        logic       eof;
    } entry_t;

    state_t        state, state_next;
    logic          frame_q, rise;
    logic [8:0]    x, y, x_next, y_next, cx, cy;
    logic [15:0]   frames_lat, cnt_inc;
    logic          last_frame;
    logic          start_cap, flush, take, restart, close;
    logic          in_frame, push_req, push_ok, long_hit, ovf;
    logic          pop, full, empty;
    entry_t        mem [FIFO_DEPTH];
    entry_t        new_entry, head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          unused_pixel_bits;

    assign unused_pixel_bits = ^pixel[7:6];

    assign rise       = frame & ~frame_q;
    assign cnt_inc    = (&frame_cnt) ? frame_cnt : frame_cnt + 16'd1;
    // The frame closing on this rise is the last one requested.
    assign last_frame = (frames_lat != 16'd0) && (cnt_inc == frames_lat);

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_cap  = 1'b0;
        flush      = 1'b0;
        take       = 1'b0;
        restart    = 1'b0;
        close      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cap_start) begin
                    state_next = S_ARM;
                    start_cap  = 1'b1;
                end
            end
            S_ARM: begin
                if (cap_abort) begin
                    state_next = S_IDLE;
                    flush      = 1'b1;
                end else if (rise) begin
                    state_next = S_CAPTURE;
                    restart    = 1'b1;
                    take       = pixel_en;
                end
            end
            S_CAPTURE: begin
                if (cap_abort) begin
                    state_next = S_IDLE;
                    flush      = 1'b1;
                end else if (rise) begin
                    close = 1'b1;
                    if (last_frame) begin
                        state_next = S_DRAIN;
                    end else begin
                        // Same-cycle pixel belongs to the new frame.
                        restart = 1'b1;
                        take    = pixel_en;
                    end
                end else begin
                    take = pixel_en;
                end
            end
            S_DRAIN: begin
                if (cap_abort) begin
                    state_next = S_IDLE;
                    flush      = 1'b1;
                end else if (empty) begin
                    state_next = S_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- pixel position ----------------
    always_comb begin
        cx       = restart ? 9'd0 : x;
        cy       = restart ? 9'd0 : y;
        in_frame = cy < Y_FULL;
        push_req = take & in_frame;
        long_hit = take & ~in_frame;
        x_next   = cx;
        y_next   = cy;
        // Advance on every in-frame pixel, even one the FIFO drops, so
        // later coordinates stay aligned with the PPU raster.
        if (push_req) begin
            if (cx == X_LAST) begin
                x_next = 9'd0;
                y_next = cy + 9'd1;
            end else begin
                x_next = cx + 9'd1;
            end
        end
        new_entry.x    = cx;
        new_entry.y    = cy[7:0];
        new_entry.data = pixel[5:0];
        new_entry.sof  = (cx == 9'd0) && (cy == 9'd0);
        new_entry.eof  = (cx == X_LAST) && (cy == Y_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q    <= 1'b0;
            x          <= 9'd0;
            y          <= 9'd0;
            frames_lat <= 16'd0;
            frame_cnt  <= 16'd0;
            err        <= 3'd0;
        end else begin
            frame_q <= frame;
            x       <= x_next;
            y       <= y_next;
            if (start_cap) begin
                frames_lat <= cap_frames;
                frame_cnt  <= 16'd0;
                err        <= 3'd0;
            end else begin
                if (close) frame_cnt <= cnt_inc;
                // y only reaches Y_FULL after every active pixel arrived.
                if (close && (y != Y_FULL)) err[0] <= 1'b1;
                if (long_hit)               err[1] <= 1'b1;
                if (ovf)                    err[2] <= 1'b1;
            end
        end
    end

    // ---------------- output FIFO ----------------
    assign empty   = (count == '0);
    assign full    = (count == FIFO_FULL);
    assign pop     = wr_valid & wr_ready;
    assign push_ok = push_req & (~full | pop);
    assign ovf     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign wr_valid  = ~empty;
    assign wr_x      = head.x;
    assign wr_y      = head.y;
    assign wr_data   = head.data;
    assign wr_sof    = head.sof;
    assign wr_eof    = head.eof;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
module tb_frame_capture_ctrl;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_ARM = 1, M_CAP = 2, M_DRAIN = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel;
    logic        pixel_en, frame, cap_start, cap_abort, wr_ready;
    logic [15:0] cap_frames;
    logic        wr_valid, wr_sof, wr_eof, busy, done;
    logic [8:0]  wr_x;
    logic [7:0]  wr_y;
    logic [5:0]  wr_data;
    logic [15:0] frame_cnt;
    logic [2:0]  err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    frame_capture_ctrl #(.IMAGE_W(W), .IMAGE_H(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pixel(pixel), .pixel_en(pixel_en), .frame(frame),
        .cap_start(cap_start), .cap_frames(cap_frames), .cap_abort(cap_abort),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .wr_sof(wr_sof), .wr_eof(wr_eof), .busy(busy),
        .done(done), .frame_cnt(frame_cnt), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          pops, sof_pops, done_pulses;
    logic        ready_v;
    logic [24:0] exp_q[$];   // model FIFO contents, head first
    logic [24:0] got_q[$];   // entries taken from the DUT
    int          m_mode, m_idx;
    logic        m_frame_prev;
    logic [15:0] m_lat, m_fcnt;
    logic [2:0]  m_err;

    function automatic logic [24:0] ent(input int x, input int y, input int d, input bit s, input bit e);
        return {9'(x), 8'(y), 6'(d), s, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode = M_IDLE; m_idx = 0; m_frame_prev = 1'b0;
        m_lat = 16'd0; m_fcnt = 16'd0; m_err = 3'd0;
    endtask

    // One accepted pixel, addressed by its raster index within the frame.
    task automatic model_pixel();
        if (m_idx >= W * H) begin
            m_err[1] = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH)
                exp_q.push_back(ent(m_idx % W, m_idx / W, int'(pixel[5:0]), m_idx == 0, m_idx == W * H - 1));
            else
                m_err[2] = 1'b1;
            m_idx++;
        end
    endtask

    task automatic model_update();
        bit was_empty, rise_now;
        if (!rst) begin
            model_reset();
            return;
        end
        was_empty    = (exp_q.size() == 0);
        rise_now     = frame && !m_frame_prev;
        m_frame_prev = frame;
        if (cap_abort && m_mode != M_IDLE) begin
            exp_q.delete();
            m_mode = M_IDLE;
            return;
        end
        if (!was_empty && wr_ready) void'(exp_q.pop_front());
        case (m_mode)
            M_IDLE: if (cap_start) begin
                m_mode = M_ARM; m_lat = cap_frames; m_fcnt = 16'd0; m_err = 3'd0;
            end
            M_ARM: if (rise_now) begin
                m_mode = M_CAP; m_idx = 0;
                if (pixel_en) model_pixel();
            end
            M_CAP: begin
                if (rise_now) begin
                    if (m_idx < W * H) m_err[0] = 1'b1;
                    if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
                    if (m_lat != 16'd0 && m_fcnt == m_lat) begin
                        m_mode = M_DRAIN;
                    end else begin
                        m_idx = 0;
                        if (pixel_en) model_pixel();
                    end
                end else if (pixel_en) begin
                    model_pixel();
                end
            end
            default: if (was_empty) m_mode = M_IDLE;
        endcase
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs at the falling edge, compares the DUT with
    // the model 1 time unit later, then advances the model past the next edge.
    task automatic step(input logic s, input logic [15:0] f, input logic fr, input logic pe,
                        input logic [7:0] px, input logic ab, input logic rd);
        @(negedge clk);
        cap_start = s; cap_frames = f; frame = fr; pixel_en = pe;
        pixel = px; cap_abort = ab; wr_ready = rd;
        #1;
        check("busy", busy, m_mode != M_IDLE);
        check("done", done, (m_mode == M_DRAIN) && (exp_q.size() == 0) && !cap_abort);
        check("frame_cnt", frame_cnt, m_fcnt);
        check("err", err, m_err);
        check("wr_valid", wr_valid, exp_q.size() != 0);
        if (wr_valid && exp_q.size() != 0)
            check("entry", {wr_x, wr_y, wr_data, wr_sof, wr_eof}, exp_q[0]);
        if (wr_valid && wr_ready) begin
            pops++;
            got_q.push_back({wr_x, wr_y, wr_data, wr_sof, wr_eof});
            if (wr_sof) sof_pops++;
        end
        if (done) done_pulses++;
        model_update();
    endtask

    task automatic idle_step();
        step(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, ready_v);
    endtask

    // Frame rise (optionally with a pixel), then the remaining pixels with
    // frame held high, then one cycle with frame low.
    task automatic run_frame(input int npix, input bit pe_on_rise);
        step(1'b0, 16'd0, 1'b1, pe_on_rise, 8'($urandom), 1'b0, ready_v);
        for (int i = 0; i < npix - int'(pe_on_rise); i++)
            step(1'b0, 16'd0, 1'b1, 1'b1, 8'($urandom), 1'b0, ready_v);
        step(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, ready_v);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            idle_step();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic clear_stats();
        pops = 0; sof_pops = 0; done_pulses = 0;
        got_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        start;
        logic [15:0] frames;
        logic        fr;
        logic        pe;
        logic [7:0]  px;
        logic        e_valid;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_cnt;
        logic [2:0]  e_err;
        logic [24:0] e_entry;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic s, input logic [15:0] f, input logic fr, input logic pe,
                                input logic [7:0] px, input logic v, input logic b, input logic d,
                                input logic [15:0] c, input logic [24:0] en);
        vec_t r;
        r.start = s; r.frames = f; r.fr = fr; r.pe = pe; r.px = px;
        r.e_valid = v; r.e_busy = b; r.e_done = d; r.e_cnt = c; r.e_err = 3'd0; r.e_entry = en;
        return r;
    endfunction

    initial begin
        // Single frame, cap_frames=1: pixel k carries index 20+k with upper bits set.
        vecs[0]  = mk(1, 16'd1, 0, 0, 8'h00, 0, 0, 0, 16'd0, '0);
        vecs[1]  = mk(0, 16'd0, 1, 0, 8'h00, 0, 1, 0, 16'd0, '0);
        vecs[2]  = mk(0, 16'd0, 1, 1, 8'hD4, 0, 1, 0, 16'd0, '0);
        vecs[3]  = mk(0, 16'd0, 1, 1, 8'hD5, 1, 1, 0, 16'd0, ent(0, 0, 20, 1, 0));
        vecs[4]  = mk(0, 16'd0, 1, 1, 8'hD6, 1, 1, 0, 16'd0, ent(1, 0, 21, 0, 0));
        vecs[5]  = mk(0, 16'd0, 1, 1, 8'hD7, 1, 1, 0, 16'd0, ent(2, 0, 22, 0, 0));
        vecs[6]  = mk(0, 16'd0, 1, 1, 8'hD8, 1, 1, 0, 16'd0, ent(3, 0, 23, 0, 0));
        vecs[7]  = mk(0, 16'd0, 1, 1, 8'hD9, 1, 1, 0, 16'd0, ent(0, 1, 24, 0, 0));
        vecs[8]  = mk(0, 16'd0, 1, 1, 8'hDA, 1, 1, 0, 16'd0, ent(1, 1, 25, 0, 0));
        vecs[9]  = mk(0, 16'd0, 1, 1, 8'hDB, 1, 1, 0, 16'd0, ent(2, 1, 26, 0, 0));
        vecs[10] = mk(0, 16'd0, 0, 0, 8'h00, 1, 1, 0, 16'd0, ent(3, 1, 27, 0, 1));
        vecs[11] = mk(0, 16'd0, 1, 0, 8'h00, 0, 1, 0, 16'd0, '0);
        vecs[12] = mk(0, 16'd0, 1, 0, 8'h00, 0, 1, 1, 16'd1, '0);
        vecs[13] = mk(0, 16'd0, 1, 0, 8'h00, 0, 0, 0, 16'd1, '0);

        rst = 1'b0; pixel = 8'd0; pixel_en = 1'b0; frame = 1'b0; cap_start = 1'b0;
        cap_frames = 16'd0; cap_abort = 1'b0; wr_ready = 1'b1; ready_v = 1'b1;
        model_reset();
        clear_stats();
        #1;
        check("rst_valid", wr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnt", frame_cnt, 16'd0);
        check("rst_err", err, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---- table: single frame ----
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].start, vecs[i].frames, vecs[i].fr, vecs[i].pe, vecs[i].px, 1'b0, 1'b1);
            check($sformatf("vec%0d_valid", i), wr_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
            check($sformatf("vec%0d_cnt", i), frame_cnt, vecs[i].e_cnt);
            check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_entry", i), {wr_x, wr_y, wr_data, wr_sof, wr_eof}, vecs[i].e_entry);
        end

        // ---- two frames, pixels on the rise cycles ----
        clear_stats();
        step(1'b1, 16'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        run_frame(8, 1'b1);
        run_frame(8, 1'b1);
        step(1'b0, 16'd0, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1);   // closing rise, pixel ignored
        wait_idle(20);
        check("f2_entries", pops, 16);
        check("f2_sof", sof_pops, 2);
        check("f2_sof_pos", got_q.size() == 16 ? got_q[8][1] : 1'b0, 1'b1);
        check("f2_done", done_pulses, 1);
        check("f2_cnt", frame_cnt, 16'd2);
        check("f2_err", err, 3'd0);

        // ---- short frame ----
        clear_stats();
        step(1'b1, 16'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        run_frame(6, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        wait_idle(20);
        check("short_err", err, 3'b001);
        check("short_cnt", frame_cnt, 16'd1);
        check("short_entries", pops, 6);

        // ---- long frame ----
        clear_stats();
        step(1'b1, 16'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        run_frame(9, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        wait_idle(20);
        check("long_err", err, 3'b010);
        check("long_entries", pops, 8);

        // ---- overflow with a stalled sink ----
        clear_stats();
        ready_v = 1'b0;
        step(1'b1, 16'd1, 1'b0, 1'b0, 8'd0, 1'b0, ready_v);
        run_frame(6, 1'b0);
        check("ovf_err", err, 3'b100);
        check("ovf_valid", wr_valid, 1'b1);
        ready_v = 1'b1;
        repeat (6) idle_step();
        check("ovf_entries", pops, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ovf_order%0d", i), got_q.size() > i ? got_q[i][24:8] : 17'h1FFFF, {9'(i), 8'd0});
        step(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1, ready_v);
        wait_idle(4);

        // ---- abort with entries buffered ----
        clear_stats();
        ready_v = 1'b0;
        step(1'b1, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, ready_v);
        run_frame(3, 1'b0);
        check("abort_pre_valid", wr_valid, 1'b1);
        step(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1, ready_v);
        idle_step();
        check("abort_valid", wr_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_no_done", done_pulses, 0);
        ready_v = 1'b1;

        // ---- reset mid-capture ----
        ready_v = 1'b0;
        step(1'b1, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, ready_v);
        run_frame(8, 1'b1);
        run_frame(3, 1'b1);
        check("rst_pre_cnt", frame_cnt, 16'd1);
        #2 rst = 1'b0;
        #1;
        check("mrst_valid", wr_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_cnt", frame_cnt, 16'd0);
        check("mrst_err", err, 3'd0);
        model_reset();
        ready_v = 1'b1;
        idle_step();
        rst = 1'b1;
        clear_stats();
        run_frame(8, 1'b1);
        run_frame(8, 1'b1);
        check("mrst_no_entries", pops, 0);
        check("mrst_idle", busy, 1'b0);

        // ---- randomized run against the model ----
        begin
            logic fr_r = 1'b0;
            int   ph_left = 3;
            for (int c = 0; c < 4000; c++) begin
                if (ph_left == 0) begin
                    fr_r    = ~fr_r;
                    ph_left = fr_r ? $urandom_range(4, 11) : $urandom_range(1, 4);
                end
                ph_left--;
                step($urandom_range(0, 24) == 0, 16'($urandom_range(0, 3)), fr_r,
                     $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 149) == 0,
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_W, default 256, active pixels per line.
REQ-002 SHALL have parameter IMAGE_H, default 240, active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pixel  in  8  PPU pixel; bits [5:0] are the palette index.
REQ-007 SHALL have port pixel_en  in  1  pixel qualifier, one pixel per asserted cycle.
REQ-008 SHALL have port frame  in  1  PPU frame level; a rising edge marks frame start.
REQ-009 SHALL have port cap_start  in  1  one-cycle capture request.
REQ-010 SHALL have port cap_frames  in  16  frame count, sampled on accepted cap_start; 0 = unlimited.
REQ-011 SHALL have port cap_abort  in  1  one-cycle abort request.
REQ-012 SHALL have port wr_valid  out  1  output entry available.
REQ-013 SHALL have port wr_ready  in  1  downstream accepts the entry.
REQ-014 SHALL have port wr_x  out  9  pixel column.
REQ-015 SHALL have port wr_y  out  8  pixel row.
REQ-016 SHALL have port wr_data  out  6  palette index.
REQ-017 SHALL have port wr_sof  out  1  entry is pixel (0,0).
REQ-018 SHALL have port wr_eof  out  1  entry is pixel (IMAGE_W-1,IMAGE_H-1).
REQ-019 SHALL have port busy  out  1  state is not IDLE.
REQ-020 SHALL have port done  out  1  one-cycle pulse on capture completion.
REQ-021 SHALL have port frame_cnt  out  16  number of completed frames in the current capture.
REQ-022 SHALL have port err  out  3  sticky flags {ovf, long, short}.

Function
REQ-023 SHALL implement states IDLE, ARM, CAPTURE, DRAIN.
REQ-024 SHALL register frame each cycle; rise = frame & ~frame_q.
REQ-025 IDLE: cap_start -> ARM; latch cap_frames; clear frame_cnt and err; cap_start outside IDLE ignored.
REQ-026 ARM: pixels ignored; on rise -> CAPTURE with x=0, y=0.
REQ-027 A pixel_en in the same cycle as the entering rise SHALL be captured as pixel (0,0).
REQ-028 CAPTURE: each pixel_en with y<IMAGE_H pushes {x,y,pixel[5:0],sof,eof}, then x increments; x==IMAGE_W-1 wraps to 0 and y increments.
REQ-029 pixel_en with y==IMAGE_H (frame already full) SHALL set err.long and not push.
REQ-030 CAPTURE rise: if fewer than IMAGE_W*IMAGE_H pixels were seen, set err.short; frame_cnt increments (saturates at 65535).
REQ-031 After that increment, if latched cap_frames!=0 and frame_cnt equals it -> DRAIN, and a pixel_en in the same cycle is ignored; otherwise counters reset and the same-cycle pixel is (0,0) of the new frame.
REQ-032 DRAIN: when the FIFO is empty -> IDLE with done pulse in the same transition cycle.
REQ-033 cap_abort in ARM/CAPTURE/DRAIN SHALL flush the FIFO, go to IDLE next cycle, and not pulse done; it has priority over all other events.
REQ-034 FIFO: wr_valid = not empty; pop on wr_valid & wr_ready; outputs reflect the head entry.
REQ-035 Push while full without a same-cycle pop SHALL drop the pixel and set err.ovf; push while full with pop SHALL be accepted.
REQ-036 Pixel counters SHALL still advance on dropped pixels so coordinates stay aligned.
REQ-037 err bits SHALL stay set until the next accepted cap_start or reset.

Reset
REQ-038 rst low SHALL immediately force IDLE, empty FIFO, wr_valid=0, busy=0, done=0, frame_cnt=0, err=0, frame_q=0.
REQ-039 Reset mid-capture SHALL discard all buffered entries; after release no entry SHALL be emitted before a new cap_start plus a frame rise.

Verification (IMAGE_W=4, IMAGE_H=2, FIFO_DEPTH=4, wr_ready=1 unless noted)
REQ-040 cap_start, cap_frames=1, rise, 8 pixel_en cycles, rise -> 8 entries (0,0)..(3,1), sof on first, eof on last, frame_cnt=1, done pulse once, err=0.
REQ-041 cap_frames=2, rise with pixel_en on the rise cycles -> 16 entries, the second frame's sof pixel is the one sampled on the second rise cycle, done after the third rise and drain.
REQ-042 Only 6 pixels before the closing rise -> err=3'b001, frame_cnt=1; 9 pixels -> err=3'b010, 8 entries emitted.
REQ-043 wr_ready=0, 6 pixels -> 4 entries held, err=3'b100; raise wr_ready -> entries (0,0)..(3,0) emitted in order.
REQ-044 cap_abort during CAPTURE with 3 entries buffered -> wr_valid=0 next cycle, state IDLE, no done pulse.
REQ-045 rst low mid-CAPTURE, then release -> all outputs at reset values; pixels before the next cap_start produce no entries.
